// File: rtl/wb_arbiter2_if.sv
// Single Wishbone link (address/data/select/we/cyc out from the master, rdt/ack back).
// The arbiter takes two of these as slave-side ports and drives one as a master.
interface wb_arbiter2_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic [DW-1:0]   rdt;
  logic            ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin two-master Wishbone arbiter (SERV ibus m0 / dbus m1) onto the peripheral bus.
// Optional forced termination of stalled grants with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_ck,
  input  logic              wb_rst_n,
  wb_arbiter2_if.slave      m0,
  wb_arbiter2_if.slave      m1,
  wb_arbiter2_if.master     s,
  output logic              timeout,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t state_r;
  state_t state_s;
  logic   last_r;
  logic   last_s;
  logic   to_hit_s;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_r;

  // Grant-age counter: held at zero in IDLE so every grant starts from 0.
  always_ff @(posedge wb_ck or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt_r <= 8'd0;
    end else if (state_r == IDLE) begin
      cnt_r <= 8'd0;
    end else if (!s.ack) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign to_hit_s = (cnt_r == TO_LAST);
`else
  logic unused_s;
  assign unused_s = &{1'b0, TO_LAST};
  assign to_hit_s = 1'b0;
`endif

  // State and round-robin history; last_r=1 means m1 was served last.
  always_ff @(posedge wb_ck or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
    end
  end

  // Next state and bus routing; everything is zero while idle.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    s.adr   = '0;
    s.dat   = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    s.cyc   = 1'b0;
    m0.rdt  = '0;
    m0.ack  = 1'b0;
    m1.rdt  = '0;
    m1.ack  = 1'b0;
    timeout = 1'b0;
    grant   = 2'b00;
    case (state_r)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_s = last_r ? G0 : G1;
        end else if (m0.cyc) begin
          state_s = G0;
        end else if (m1.cyc) begin
          state_s = G1;
        end else begin
          state_s = IDLE;
        end
      end
      G0: begin
        grant  = 2'b01;
        s.adr  = m0.adr;
        s.dat  = m0.dat;
        s.sel  = m0.sel;
        s.we   = m0.we;
        s.cyc  = m0.cyc;
        m0.ack = s.ack;
        m0.rdt = s.rdt;
        if (s.ack) begin
          state_s = IDLE;
          last_s  = 1'b0;
        end else if (to_hit_s && m0.cyc) begin
          m0.ack  = 1'b1;
          m0.rdt  = '1;
          timeout = 1'b1;
          state_s = IDLE;
          last_s  = 1'b0;
        end else if (!m0.cyc) begin
          state_s = IDLE;
        end else begin
          state_s = G0;
        end
      end
      G1: begin
        grant  = 2'b10;
        s.adr  = m1.adr;
        s.dat  = m1.dat;
        s.sel  = m1.sel;
        s.we   = m1.we;
        s.cyc  = m1.cyc;
        m1.ack = s.ack;
        m1.rdt = s.rdt;
        if (s.ack) begin
          state_s = IDLE;
          last_s  = 1'b1;
        end else if (to_hit_s && m1.cyc) begin
          m1.ack  = 1'b1;
          m1.rdt  = '1;
          timeout = 1'b1;
          state_s = IDLE;
          last_s  = 1'b1;
        end else if (!m1.cyc) begin
          state_s = IDLE;
        end else begin
          state_s = G1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a scoreboard of expected master acks is checked by a
// negedge monitor, while the main sequence checks grant/bus routing step by step.
module tb_wb_arbiter2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timeout;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] rdt;
  } exp_t;
  exp_t sb_q[$];

  wb_arbiter2_if #(.AW(32), .DW(32)) m0b ();
  wb_arbiter2_if #(.AW(32), .DW(32)) m1b ();
  wb_arbiter2_if #(.AW(32), .DW(32)) sb ();

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .wb_ck    (clk),
    .wb_rst_n (rst_n),
    .m0       (m0b),
    .m1       (m1b),
    .s        (sb),
    .timeout  (timeout),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] who, input logic [31:0] rdt);
    exp_t e;
    e.who = who;
    e.rdt = rdt;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: every master ack must match the next expected transaction.
  always @(negedge clk) begin
    if (m0b.ack || m1b.ack) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ack", {62'd0, m1b.ack, m0b.ack}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ack_who", {62'd0, m1b.ack, m0b.ack}, {62'd0, e.who});
        chk("ack_rdt", {32'd0, (m0b.ack ? m0b.rdt : m1b.rdt)}, {32'd0, e.rdt});
        chk("other_rdt", {32'd0, (m0b.ack ? m1b.rdt : m0b.rdt)}, 64'd0);
      end
    end
  end

  initial begin
    m0b.adr = 32'd0; m0b.dat = 32'd0; m0b.sel = 4'd0; m0b.we = 1'b0; m0b.cyc = 1'b0;
    m1b.adr = 32'd0; m1b.dat = 32'd0; m1b.sel = 4'd0; m1b.we = 1'b0; m1b.cyc = 1'b0;
    sb.rdt = 32'd0; sb.ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_scyc", {63'd0, sb.cyc}, 64'd0);
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_timeout", {63'd0, timeout}, 64'd0);
    nxt(); rst_n = 1'b1;

    // Single m0 read, slave acks two cycles after s_cyc rises
    nxt(); m0b.cyc = 1'b1; m0b.adr = 32'h4000_0000; m0b.sel = 4'hf; m0b.dat = 32'hdead_beef;
    @(negedge clk);
    chk("t1_req_scyc", {63'd0, sb.cyc}, 64'd0);
    chk("t1_req_grant", {62'd0, grant}, 64'd0);
    nxt(); @(negedge clk);
    chk("t1_scyc", {63'd0, sb.cyc}, 64'd1);
    chk("t1_sadr", {32'd0, sb.adr}, 64'h4000_0000);
    chk("t1_sdat", {32'd0, sb.dat}, 64'hdead_beef);
    chk("t1_grant", {62'd0, grant}, 64'd1);
    nxt(); @(negedge clk);
    nxt(); sb.ack = 1'b1; sb.rdt = 32'h1234_5678; push(2'b01, 32'h1234_5678);
    @(negedge clk);
    nxt(); sb.ack = 1'b0; m0b.cyc = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", {63'd0, m0b.ack}, 64'd0);
    chk("t1_idle_grant", {62'd0, grant}, 64'd0);

    // Reset in the middle of a G0 grant
    nxt(); m0b.cyc = 1'b1; m0b.adr = 32'h4000_0010;
    @(negedge clk);
    nxt(); @(negedge clk);
    chk("t4_scyc_before", {63'd0, sb.cyc}, 64'd1);
    #2; rst_n = 1'b0;
    #1; sb.ack = 1'b1;
    #1;
    chk("t4_async_scyc", {63'd0, sb.cyc}, 64'd0);
    chk("t4_async_ack", {63'd0, m0b.ack}, 64'd0);
    chk("t4_async_grant", {62'd0, grant}, 64'd0);
    nxt(); sb.ack = 1'b0; m0b.cyc = 1'b0;
    @(negedge clk);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("t4_post_grant", {62'd0, grant}, 64'd0);

    // Simultaneous requests after reset: m0, idle gap, m1, then m0 wins again
    nxt(); m0b.cyc = 1'b1; m1b.cyc = 1'b1; m0b.adr = 32'h4000_0020; m1b.adr = 32'h8000_0004;
    @(negedge clk);
    nxt(); sb.ack = 1'b1; sb.rdt = 32'haaaa_0000; push(2'b01, 32'haaaa_0000);
    @(negedge clk);
    chk("t2_first_grant", {62'd0, grant}, 64'd1);
    chk("t2_first_adr", {32'd0, sb.adr}, 64'h4000_0020);
    nxt(); sb.ack = 1'b0; m0b.cyc = 1'b0;
    @(negedge clk);
    chk("t2_gap_grant", {62'd0, grant}, 64'd0);
    chk("t2_gap_scyc", {63'd0, sb.cyc}, 64'd0);
    nxt(); sb.ack = 1'b1; sb.rdt = 32'hbbbb_1111; push(2'b10, 32'hbbbb_1111);
    @(negedge clk);
    chk("t2_second_grant", {62'd0, grant}, 64'd2);
    chk("t2_second_adr", {32'd0, sb.adr}, 64'h8000_0004);
    nxt(); sb.ack = 1'b0; m1b.cyc = 1'b0;
    @(negedge clk);
    nxt(); m0b.cyc = 1'b1; m1b.cyc = 1'b1;
    @(negedge clk);
    nxt(); sb.ack = 1'b1; sb.rdt = 32'hcccc_2222; push(2'b01, 32'hcccc_2222);
    @(negedge clk);
    chk("t2_rr_grant", {62'd0, grant}, 64'd1);
    nxt(); sb.ack = 1'b0; m0b.cyc = 1'b0; m1b.cyc = 1'b0;
    @(negedge clk);

    // m1 aborts before ack; last stays at m0 so m1 wins the next tie
    nxt(); m1b.cyc = 1'b1; m1b.adr = 32'h8000_0008;
    @(negedge clk);
    nxt(); @(negedge clk);
    chk("t3_grant", {62'd0, grant}, 64'd2);
    nxt(); m1b.cyc = 1'b0;
    @(negedge clk);
    chk("t3_drop_scyc", {63'd0, sb.cyc}, 64'd0);
    nxt(); @(negedge clk);
    chk("t3_idle_grant", {62'd0, grant}, 64'd0);
    nxt(); m0b.cyc = 1'b1; m1b.cyc = 1'b1;
    @(negedge clk);
    nxt(); sb.ack = 1'b1; sb.rdt = 32'hdddd_3333; push(2'b10, 32'hdddd_3333);
    @(negedge clk);
    chk("t3_last_kept", {62'd0, grant}, 64'd2);
    nxt(); sb.ack = 1'b0; m0b.cyc = 1'b0; m1b.cyc = 1'b0;
    @(negedge clk);

    // s_ack while idle is not forwarded
    nxt(); sb.ack = 1'b1; sb.rdt = 32'h5555_aaaa;
    @(negedge clk);
    chk("t6_m0_ack", {63'd0, m0b.ack}, 64'd0);
    chk("t6_m1_ack", {63'd0, m1b.ack}, 64'd0);
    nxt(); sb.ack = 1'b0;
    @(negedge clk);
    chk("t6_grant", {62'd0, grant}, 64'd0);
    chk("t6_scyc", {63'd0, sb.cyc}, 64'd0);

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled grant is forced off on the 4th s_cyc cycle
    nxt(); m0b.cyc = 1'b1; m0b.adr = 32'h4000_0030;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      nxt(); @(negedge clk);
      chk("to_wait_timeout", {63'd0, timeout}, 64'd0);
      chk("to_wait_scyc", {63'd0, sb.cyc}, 64'd1);
    end
    nxt(); push(2'b01, 32'hffff_ffff);
    @(negedge clk);
    chk("to_fire", {63'd0, timeout}, 64'd1);
    nxt(); m0b.cyc = 1'b0;
    @(negedge clk);
    chk("to_after_grant", {62'd0, grant}, 64'd0);
    chk("to_after_pulse", {63'd0, timeout}, 64'd0);
    nxt(); m0b.cyc = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      nxt(); @(negedge clk);
    end
    nxt(); sb.ack = 1'b1; sb.rdt = 32'h5a5a_5a5a; push(2'b01, 32'h5a5a_5a5a);
    @(negedge clk);
    chk("to_ack_wins", {63'd0, timeout}, 64'd0);
    nxt(); sb.ack = 1'b0; m0b.cyc = 1'b0;
    @(negedge clk);
`else
    // Without forced termination a grant waits indefinitely
    nxt(); m0b.cyc = 1'b1; m0b.adr = 32'h4000_0030;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      nxt(); @(negedge clk);
      chk("nto_timeout", {63'd0, timeout}, 64'd0);
      chk("nto_grant", {62'd0, grant}, 64'd1);
    end
    nxt(); m0b.cyc = 1'b0;
    @(negedge clk);
`endif

    nxt(); @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone arbiter between the SERV instruction bus (m0) and data bus (m1) and the shared peripheral bus.
- The peripheral bus fans out to the per-peripheral chip_select decoders.
- Grants one master at a time with round-robin priority and holds the grant until the slave acks or the master drops cyc.
- Its outputs are the addr/wb_cyc consumed by the chip selects; their ack returns through it.

Parameters:
- AW, 32, address width of masters and slave.
- DW, 32, data width.
- TIMEOUT, 255, cycles in a grant without s_ack before forced termination (used only with WB_ARB_TIMEOUT_EN); valid range 1..255 (8-bit counter).

Ports:
- wb_ck  in  1  bus clock, all state on rising edge
- wb_rst_n  in  1  asynchronous active-low reset
- m0_adr  in  AW  master 0 address
- m0_dat  in  DW  master 0 write data
- m0_sel  in  DW/8  master 0 byte selects
- m0_we  in  1  master 0 write enable
- m0_cyc  in  1  master 0 cycle request
- m0_rdt  out  DW  master 0 read data
- m0_ack  out  1  master 0 acknowledge
- m1_adr, m1_dat, m1_sel, m1_we, m1_cyc, m1_rdt, m1_ack: same as m0, for master 1
- s_adr  out  AW  slave address (to chip_select addr)
- s_dat  out  DW  slave write data
- s_sel  out  DW/8  slave byte selects
- s_we  out  1  slave write enable
- s_cyc  out  1  slave cycle (to chip_select wb_cyc)
- s_rdt  in  DW  slave read data
- s_ack  in  1  slave acknowledge (OR of chip_select acks)
- timeout  out  1  one-cycle pulse on forced termination; tied 0 without the macro
- grant  out  2  one-hot current grant {m1,m0}; 00 when idle

Behaviour:
- Reset, asserted asynchronously: state=IDLE, last=1 (m0 wins the first tie), grant=00, all outputs 0.
- FSM states: IDLE, G0, G1. State and last are registered.
- IDLE:
  - m0_cyc only -> G0. m1_cyc only -> G1.
  - Both -> the master not equal to last.
  - Neither -> stay in IDLE.
- Grant latency: request seen in cycle N, s_cyc high in cycle N+1. s_cyc is never driven in IDLE.
- Gx (combinational from state):
  - s_adr/s_dat/s_sel/s_we = mx_*, s_cyc = mx_cyc.
  - mx_ack = s_ack, mx_rdt = s_rdt.
  - Non-granted master: ack=0, rdt=0.
- Gx exits:
  - s_ack=1 -> IDLE, last<=x.
  - mx_cyc=0 (abort) -> IDLE, last unchanged.
  - Both in the same cycle -> treat as ack.
- No back-to-back grants: at least one IDLE cycle between transactions. This guarantees the chip_select state machines see wb_cyc fall and reset to 0.
- Non-granted mx_cyc may stay high indefinitely without effect until IDLE.
- s_ack arriving in IDLE is ignored and not forwarded.
- In IDLE all s_* outputs are 0 and grant=00.
- Reset mid-transaction: s_cyc and acks fall asynchronously with reset; no ack is generated.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- With it:
  - An 8-bit counter clears on entry to G0/G1 and increments each cycle in Gx without s_ack.
  - When count == TIMEOUT-1 and s_ack=0: mx_ack=1 and mx_rdt={DW{1'b1}} that cycle, timeout=1 for one cycle, then IDLE with last<=x.
  - s_ack in that same cycle takes precedence: normal ack, no timeout.
- Without it: no counter, timeout=0 constant, a grant waits forever for s_ack or a drop of cyc.

Test Plan:
- m0_cyc=1 alone, m0_adr=0x40000000, slave acks 2 cycles after s_cyc -> s_cyc high 1 cycle after request, m0_ack single-cycle pulse, m0_rdt=s_rdt (0x12345678) that cycle, m1_ack=0.
- m0_cyc and m1_cyc rise together after reset -> m0 served first, then an IDLE cycle, then m1. On the next simultaneous request m0 wins again because last=1.
- m1 granted, m1_cyc dropped before s_ack -> IDLE next cycle, no ack to either master, last unchanged, grant=00.
- wb_rst_n pulled low while in G0 with s_cyc=1 -> s_cyc, m0_ack and grant go 0 without waiting for a clock edge. After release the FSM is in IDLE and last=1.
- WB_ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks -> m0_ack=1, m0_rdt=0xFFFFFFFF and timeout=1 on the 4th cycle of s_cyc, then IDLE. Repeat with s_ack on that 4th cycle -> normal ack, timeout=0.
- s_ack pulsed while in IDLE -> m0_ack=m1_ack=0, state stays IDLE.
